// File: rtl/redun_carry_normalizer_pkg.sv
// Shared types and helpers for the redundant-form carry normalizer and its
// multiplier-side neighbours.
package redun_carry_normalizer_pkg;

    localparam int unsigned DSP_BIT_LEN_DEF = 17;
    localparam int unsigned WORD_LEN_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE,
        PROP,
        DONE
    } state_t;

    typedef logic [DSP_BIT_LEN_DEF-1:0] word_t;

    // Upper (carry) bits of a word; callers zero-extend words up to 32 bits.
    function automatic logic [31:0] carry_bits(input logic [31:0] word,
                                               input int unsigned word_len);
        return word >> word_len;
    endfunction

endpackage

// File: rtl/redun_carry_pass.sv
// One parallel carry-propagation pass over a redundant vector, with
// pending-carry and top-word overflow flags.
module redun_carry_pass
    import redun_carry_normalizer_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS = 66,
    parameter int unsigned DSP_BIT_LEN  = 17,
    parameter int unsigned WORD_LEN     = 16
) (
    input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] w,
    output logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] nxt,
    output logic                                     pend,
    output logic                                     ovf
);

    logic [NUM_ELEMENTS-2:0][DSP_BIT_LEN-1:0] carry;
    logic [DSP_BIT_LEN:0]                     top_sum;

    always_comb begin
        carry   = '0;
        pend    = 1'b0;
        nxt     = w;
        for (int unsigned i = 0; i < NUM_ELEMENTS - 1; i++) begin
            carry[i] = DSP_BIT_LEN'(carry_bits(32'(w[i]), WORD_LEN));
            pend     = pend | (|carry[i]);
        end
        nxt[0] = DSP_BIT_LEN'(w[0][WORD_LEN-1:0]);
        for (int unsigned i = 1; i < NUM_ELEMENTS - 1; i++) begin
            nxt[i] = DSP_BIT_LEN'(w[i][WORD_LEN-1:0]) + carry[i-1];
        end
        // Top word keeps its own upper bits; only a carry out of it is flagged.
        top_sum            = {1'b0, w[NUM_ELEMENTS-1]} + {1'b0, carry[NUM_ELEMENTS-2]};
        ovf                = top_sum[DSP_BIT_LEN];
        nxt[NUM_ELEMENTS-1] = top_sum[DSP_BIT_LEN-1:0];
    end

endmodule

// File: rtl/redun_carry_normalizer.sv
// Iteratively normalizes a redundant-form product vector until every word
// below the top is canonical, then hands it downstream over valid/ready.
module redun_carry_normalizer
    import redun_carry_normalizer_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS = 66,
    parameter int unsigned DSP_BIT_LEN  = 17,
    parameter int unsigned WORD_LEN     = 16,
    parameter int unsigned MAX_ITER     = NUM_ELEMENTS + 1,
    localparam int unsigned ITER_W      = $clog2(MAX_ITER + 1)
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst_n,
    input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] i_dat,
    input  logic                                     i_val,
    output logic                                     o_rdy,
    output logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] o_dat,
    output logic                                     o_val,
    input  logic                                     i_rdy,
    output logic                                     o_ovf,
    output logic                                     o_err,
    output logic [ITER_W-1:0]                        o_iter
);

    state_t                                   state_q, state_d;
    logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] w_q, w_d, pass_nxt;
    logic                                     ovf_q, ovf_d;
    logic                                     err_q, err_d;
    logic                                     val_q, val_d;
    logic [ITER_W-1:0]                        iter_q, iter_d;
    logic                                     pass_pend, pass_ovf;

    redun_carry_pass #(
        .NUM_ELEMENTS (NUM_ELEMENTS),
        .DSP_BIT_LEN  (DSP_BIT_LEN),
        .WORD_LEN     (WORD_LEN)
    ) u_pass (
        .w    (w_q),
        .nxt  (pass_nxt),
        .pend (pass_pend),
        .ovf  (pass_ovf)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            val_q   <= 1'b0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            val_q   <= val_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        val_d   = val_q;
        iter_d  = iter_q;
        unique case (state_q)
            IDLE: begin
                if (i_val) begin
                    w_d     = i_dat;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    iter_d  = '0;
                    state_d = PROP;
                end
            end
            PROP: begin
                if (!pass_pend) begin
                    val_d   = 1'b1;
                    state_d = DONE;
                end else if (iter_q == ITER_W'(MAX_ITER)) begin
                    err_d   = 1'b1;
                    val_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    w_d    = pass_nxt;
                    ovf_d  = ovf_q | pass_ovf;
                    iter_d = iter_q + ITER_W'(1);
                end
            end
            DONE: begin
                if (i_rdy) begin
                    val_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_rdy  = (state_q == IDLE);
    assign o_dat  = w_q;
    assign o_val  = val_q;
    assign o_ovf  = ovf_q;
    assign o_err  = err_q;
    assign o_iter = iter_q;

endmodule
